// File: rtl/inst_issue_pkg.sv
// Shared instruction-word layout and FSM encoding for the issue side.
// The parser uses the same field offsets.
package inst_pkg;
    localparam int DW       = 32;
    localparam int RUN_BIT  = 31;
    localparam int ID_HI    = 30;
    localparam int ID_LO    = 28;
    localparam int ADDR_HI  = 27;
    localparam int ADDR_LO  = 24;
    localparam int PRIOR_HI = 23;
    localparam int PRIOR_LO = 22;
    localparam int RFU_HI   = 21;
    localparam int RFU_LO   = 16;
    localparam int DATA_HI  = 15;
    localparam int DATA_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    function automatic logic [31:0] pack_word(
        input logic        run,
        input logic [2:0]  id,
        input logic [3:0]  addr,
        input logic [1:0]  prior,
        input logic [15:0] data
    );
        logic [31:0] w;
        w                    = '0;
        w[RUN_BIT]           = run;
        w[ID_HI:ID_LO]       = id;
        w[ADDR_HI:ADDR_LO]   = addr;
        w[PRIOR_HI:PRIOR_LO] = prior;
        w[RFU_HI:RFU_LO]     = '0;
        w[DATA_HI:DATA_LO]   = data;
        return w;
    endfunction
endpackage

// File: rtl/inst_issue_out_reg.sv
// Valid/ready output holding register; word and its end-of-command tag
// stay frozen while the downstream stalls.
module inst_out_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    output logic          adv
);
    assign adv = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (load && adv) begin
            m_data  <= load_data;
            m_valid <= 1'b1;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/inst_issue.sv
// Instruction-stream transmitter: serializes a command into load words plus
// an optional run word. Define INST_ISSUE_STAT_EN to add the issue_cnt port.
module inst_issue
    import inst_pkg::*;
#(
    parameter int IN = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    cmd_id,
    input  logic [3:0]    cmd_len,
    input  logic [1:0]    cmd_prior,
    input  logic          cmd_run,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [15:0]   cfg_data,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic [DW-1:0] inst_m_data,
    output logic          inst_m_valid,
    input  logic          inst_m_ready,
    output logic          busy,
`ifdef INST_ISSUE_STAT_EN
    output logic [15:0]   issue_cnt,
`endif
    output logic          done
);
    localparam logic [3:0] IN_L = 4'(IN);

    state_t      state;
    logic [2:0]  id_q;
    logic [3:0]  len_q;
    logic [1:0]  prior_q;
    logic        run_q;
    logic [3:0]  idx;
    logic        adv;
    logic        out_last;
    logic        ld;
    logic [DW-1:0] ld_word;
    logic        ld_last;
    logic        cmd_fire;
    logic        cfg_fire;
    logic        out_hs;
    logic        last_idx;
    logic [3:0]  len_clamped;

    assign cmd_ready   = (state == ST_IDLE);
    assign cfg_ready   = (state == ST_LOAD) && adv;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign cfg_fire    = cfg_valid && cfg_ready;
    assign out_hs      = inst_m_valid && inst_m_ready;
    assign last_idx    = (idx == len_q - 4'd1);
    assign len_clamped = (cmd_len > IN_L) ? IN_L : cmd_len;
    assign busy        = (state != ST_IDLE) || inst_m_valid;

    always_comb begin
        ld      = 1'b0;
        ld_word = '0;
        ld_last = 1'b0;
        case (state)
            ST_LOAD: if (cfg_fire) begin
                ld      = 1'b1;
                ld_word = pack_word(1'b0, id_q, idx, prior_q, cfg_data);
                ld_last = last_idx && !run_q;
            end
            ST_RUN: if (adv) begin
                ld      = 1'b1;
                ld_word = pack_word(1'b1, id_q, 4'd0, prior_q, 16'h0);
                ld_last = 1'b1;
            end
            default: ;
        endcase
    end

    // done follows the handshake of the word tagged as the command's last
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            id_q    <= '0;
            len_q   <= '0;
            prior_q <= '0;
            run_q   <= 1'b0;
            idx     <= '0;
            done    <= 1'b0;
        end else begin
            done <= out_hs && out_last;
            case (state)
                ST_IDLE: if (cmd_fire) begin
                    id_q    <= cmd_id;
                    len_q   <= len_clamped;
                    prior_q <= cmd_prior;
                    run_q   <= cmd_run;
                    idx     <= '0;
                    if (len_clamped != 4'd0) state <= ST_LOAD;
                    else if (cmd_run)        state <= ST_RUN;
                    else                     done  <= 1'b1;
                end
                ST_LOAD: if (cfg_fire) begin
                    idx <= idx + 4'd1;
                    if (last_idx) state <= run_q ? ST_RUN : ST_IDLE;
                end
                ST_RUN: if (adv) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    inst_out_reg #(.DW(DW)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .load_data (ld_word),
        .load_last (ld_last),
        .m_ready   (inst_m_ready),
        .m_data    (inst_m_data),
        .m_valid   (inst_m_valid),
        .m_last    (out_last),
        .adv       (adv)
    );

`ifdef INST_ISSUE_STAT_EN
    always_ff @(posedge clk) begin
        if (rst)         issue_cnt <= '0;
        else if (out_hs) issue_cnt <= issue_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_inst_issue.sv
// Directed bench for inst_issue: word format, stalls, clamp, reset, back-to-back.
module tb_inst_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cmd_id;
    logic [3:0]  cmd_len;
    logic [1:0]  cmd_prior;
    logic        cmd_run;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] inst_m_data;
    logic        inst_m_valid;
    logic        inst_m_ready;
    logic        busy;
    logic        done;
`ifdef INST_ISSUE_STAT_EN
    logic [15:0] issue_cnt;
`endif

    always #5 clk = ~clk;

    inst_issue #(.IN(6), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_id       (cmd_id),
        .cmd_len      (cmd_len),
        .cmd_prior    (cmd_prior),
        .cmd_run      (cmd_run),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .inst_m_data  (inst_m_data),
        .inst_m_valid (inst_m_valid),
        .inst_m_ready (inst_m_ready),
        .busy         (busy),
`ifdef INST_ISSUE_STAT_EN
        .issue_cnt    (issue_cnt),
`endif
        .done         (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int hs_total = 0;
    logic [15:0] cfg_mem [16];
    int cfg_n = 0;
    int cfg_ptr = 0;
    logic [31:0] got_q [$];
    int hs_q [$];
    int done_q [$];

    function automatic logic [31:0] exp_load(input logic [2:0] id, input logic [3:0] addr,
                                             input logic [1:0] prior, input logic [15:0] data);
        return {1'b0, id, addr, prior, 6'b0, data};
    endfunction

    function automatic logic [31:0] got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : 32'hxxxxxxxx;
    endfunction

    task automatic drive_cfg();
        cfg_valid = (cfg_ptr < cfg_n);
        cfg_data  = (cfg_ptr < 16) ? cfg_mem[cfg_ptr] : 16'h0;
    endtask

    task automatic clear_cfg();
        cfg_n = 0;
        cfg_ptr = 0;
        drive_cfg();
    endtask

    task automatic push_cfg(input logic [15:0] v);
        cfg_mem[cfg_n] = v;
        cfg_n++;
        drive_cfg();
    endtask

    task automatic clear_log();
        got_q.delete();
        hs_q.delete();
        done_q.delete();
    endtask

    // Samples mid-cycle, then advances one clock and applies consequences.
    task automatic tick();
        logic ho, hc, hm;
        #1;
        ho = inst_m_valid && inst_m_ready;
        hc = cfg_valid && cfg_ready;
        hm = cmd_valid && cmd_ready;
        if (!rst) begin
            if (ho) begin
                got_q.push_back(inst_m_data);
                hs_q.push_back(cyc);
                hs_total++;
            end
            if (done) done_q.push_back(cyc);
            if (hm) acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) hs_total = 0;
        if (hc) cfg_ptr++;
        if (hm) cmd_valid = 1'b0;
        drive_cfg();
    endtask

    task automatic issue(input logic [2:0] id, input logic [3:0] len,
                         input logic [1:0] prior, input logic run);
        cmd_id = id; cmd_len = len; cmd_prior = prior; cmd_run = run;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && cmd_valid; i++) tick();
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL cmd_accept: command still pending after 50 cycles");
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_q.size() < n; i++) tick();
        total++;
        if (done_q.size() < n) begin
            bad++;
            $display("FAIL done_timeout: got %0d done pulses, need %0d", done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; inst_m_ready = 1'b0;
        cmd_id = '0; cmd_len = '0; cmd_prior = '0; cmd_run = 1'b0;
        clear_cfg();
        tick(); tick();
        total++; if (inst_m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", inst_m_valid); end
        total++; if (inst_m_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=00000000", inst_m_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_cfg_ready got=%b exp=0", cfg_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp [3];
        exp = '{32'h3040AAAA, 32'h31405555, 32'hB0400000};
        clear_log(); clear_cfg();
        push_cfg(16'hAAAA); push_cfg(16'h5555);
        inst_m_ready = 1'b1;
        issue(3'd3, 4'd2, 2'd1, 1'b1);
        wait_done(1, 30);
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_at(i) !== exp[i]) begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_at(i), exp[i]); end
        end
        total++; if (hs_q.size() < 1 || hs_q[0] != acc_cyc + 2) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", (hs_q.size() > 0) ? hs_q[0] : -1, acc_cyc + 2); end
        total++; if (hs_q.size() < 3 || done_q.size() < 1 || done_q[0] != hs_q[2] + 1) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=last_hs+1", (done_q.size() > 0) ? done_q[0] : -1); end
        total++; if (cfg_ptr != 2) begin bad++; $display("FAIL basic_cfg_used got=%0d exp=2", cfg_ptr); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_stall();
        logic [31:0] exp [3];
        logic [31:0] held;
        exp = '{32'h3040AAAA, 32'h31405555, 32'hB0400000};
        clear_log(); clear_cfg();
        push_cfg(16'hAAAA); push_cfg(16'h5555);
        inst_m_ready = 1'b0;
        issue(3'd3, 4'd2, 2'd1, 1'b1);
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 20 && !inst_m_valid; j++) tick();
            held = inst_m_data;
            total++; if (held !== exp[w]) begin bad++; $display("FAIL stall_word%0d got=%h exp=%h", w, held, exp[w]); end
            for (int k = 0; k < 5; k++) begin
                tick();
                total++;
                if (inst_m_valid !== 1'b1 || inst_m_data !== held || cfg_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_hold%0d got=v%b/%h/cr%b exp=v1/%h/cr0", w, inst_m_valid, inst_m_data, cfg_ready, held);
                end
            end
            inst_m_ready = 1'b1;
            tick();
            inst_m_ready = 1'b0;
        end
        wait_done(1, 20);
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL stall_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_at(i) !== exp[i]) begin bad++; $display("FAIL stall_seq%0d got=%h exp=%h", i, got_at(i), exp[i]); end
        end
        inst_m_ready = 1'b1;
    endtask

    task automatic test_zero();
        clear_log(); clear_cfg();
        issue(3'd2, 4'd0, 2'd0, 1'b0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL zero_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
        total++; if (done_q.size() != 1 || done_q[0] != acc_cyc + 1) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=%0d", (done_q.size() > 0) ? done_q[0] : -1, acc_cyc + 1); end
        repeat (3) tick();
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL zero_words got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_clamp();
        clear_log(); clear_cfg();
        for (int i = 0; i < 7; i++) push_cfg(16'h1000 + 16'(i));
        inst_m_ready = 1'b1;
        issue(3'd1, 4'd9, 2'd2, 1'b0);
        wait_done(1, 40);
        repeat (2) tick();
        total++; if (got_q.size() != 6) begin bad++; $display("FAIL clamp_count got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (got_at(i) !== exp_load(3'd1, 4'(i), 2'd2, 16'h1000 + 16'(i))) begin
                bad++;
                $display("FAIL clamp_word%0d got=%h exp=%h", i, got_at(i), exp_load(3'd1, 4'(i), 2'd2, 16'h1000 + 16'(i)));
            end
        end
        total++; if (cfg_ptr != 6) begin bad++; $display("FAIL clamp_cfg_used got=%0d exp=6", cfg_ptr); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL clamp_cfg_ready got=%b exp=0", cfg_ready); end
    endtask

    task automatic test_reset_mid();
        clear_log(); clear_cfg();
        for (int i = 0; i < 4; i++) push_cfg(16'h2000 + 16'(i));
        inst_m_ready = 1'b1;
        issue(3'd2, 4'd4, 2'd1, 1'b1);
        for (int j = 0; j < 20 && got_q.size() < 1; j++) tick();
        inst_m_ready = 1'b0;
        rst = 1'b1;
        tick();
        total++; if (inst_m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", inst_m_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_cmd_ready got=%b exp=1", cmd_ready); end
        rst = 1'b0;
        clear_cfg(); clear_log();
        push_cfg(16'hBEEF); push_cfg(16'h0123);
        inst_m_ready = 1'b1;
        issue(3'd5, 4'd2, 2'd3, 1'b0);
        wait_done(1, 30);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL rstmid_count got=%0d exp=2", got_q.size()); end
        total++; if (got_at(0) !== 32'h50C0BEEF) begin bad++; $display("FAIL rstmid_word0 got=%h exp=50c0beef", got_at(0)); end
        total++; if (got_at(1) !== 32'h51C00123) begin bad++; $display("FAIL rstmid_word1 got=%h exp=51c00123", got_at(1)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4];
        int a, b;
        exp = '{32'h40000001, 32'h41000002, 32'hC0000000, 32'h60800003};
        clear_log(); clear_cfg();
        push_cfg(16'h0001); push_cfg(16'h0002); push_cfg(16'h0003);
        inst_m_ready = 1'b1;
        issue(3'd4, 4'd2, 2'd0, 1'b1);
        a = acc_cyc;
        issue(3'd6, 4'd1, 2'd2, 1'b0);
        b = acc_cyc;
        wait_done(2, 40);
        total++; if (b != a + 4) begin bad++; $display("FAIL b2b_accept got=%0d exp=%0d", b, a + 4); end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_at(i) !== exp[i]) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got_at(i), exp[i]); end
        end
        total++;
        if (hs_q.size() != 4 || hs_q[0] != a + 2 || hs_q[1] != a + 3 || hs_q[2] != a + 4 || hs_q[3] != a + 6) begin
            bad++;
            $display("FAIL b2b_timing got=%p exp=+2,+3,+4,+6 from %0d", hs_q, a);
        end
        total++; if (done_q.size() < 2 || done_q[0] != a + 5 || done_q[1] != a + 7) begin bad++; $display("FAIL b2b_done got=%p exp=%0d,%0d", done_q, a + 5, a + 7); end
`ifdef INST_ISSUE_STAT_EN
        total++; if (issue_cnt !== 16'(hs_total)) begin bad++; $display("FAIL stat_cnt got=%0d exp=%0d", issue_cnt, hs_total); end
        total++; if (issue_cnt !== 16'd6) begin bad++; $display("FAIL stat_cnt_abs got=%0d exp=6", issue_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
